// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the PC sequencer: branch FSM states, default widths,
// reset PC and sign extension of the C-field branch offset.
package branch_pc_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESOLVE = 2'd2
   } br_state_e;

   localparam int PC_W     = 32;
   localparam int OFFSET_W = 19;
   localparam int STAT_W   = 16;

   localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

   function automatic logic signed [PC_W-1:0] sext_c(input logic [OFFSET_W-1:0] c);
      return signed'({{(PC_W-OFFSET_W){c[OFFSET_W-1]}}, c});
   endfunction

endpackage

// File: rtl/branch_wait_counter.sv
// Loadable down-counter with zero flag; holds at zero. Used to delay a
// multi-cycle control step by a fixed number of cycles.
module branch_wait_counter
   import branch_pc_unit_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             cnt_zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with fetch increment, bus load and conditional relative
// branch resolved against the CON flag. Optional stats: BRANCH_STATS_EN.
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter int                  PC_WIDTH     = PC_W,
   parameter int                  OFFSET_WIDTH = OFFSET_W,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(RESET_PC_DEF),
   parameter int                  CON_WAIT     = 1
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                pc_inc,
   input  logic                pc_in_en,
   input  logic [PC_WIDTH-1:0] bus_in,
   input  logic                br_start,
   input  logic [31:0]         ir_in,
   input  logic                con_in,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                busy,
   output logic                br_done,
   output logic                br_taken
`ifdef BRANCH_STATS_EN
   ,
   output logic [STAT_W-1:0]   taken_cnt,
   output logic [STAT_W-1:0]   not_taken_cnt
`endif
);

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CON_WAIT - 1);

   br_state_e                   state_q, state_d;
   logic [PC_WIDTH-1:0]         pc_q, pc_d;
   logic signed [PC_WIDTH-1:0]  off_q, off_ext;
   logic                        cnt_load, cnt_dec, cnt_zero;
   logic                        done_d, taken_d;
   logic                        unused_ir;

   assign unused_ir = ^ir_in[31:OFFSET_WIDTH];

   generate
      if (PC_WIDTH == PC_W && OFFSET_WIDTH == OFFSET_W) begin : g_sext_pkg
         assign off_ext = sext_c(ir_in[OFFSET_W-1:0]);
      end else begin : g_sext_gen
         assign off_ext = signed'({{(PC_WIDTH-OFFSET_WIDTH){ir_in[OFFSET_WIDTH-1]}},
                                   ir_in[OFFSET_WIDTH-1:0]});
      end
   endgenerate

   branch_wait_counter #(
      .CNT_W    (CNT_W)
   ) u_wait_cnt (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .cnt_zero (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      done_d   = 1'b0;
      taken_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pc_inc) begin
               pc_d = pc_q + PC_WIDTH'(1);
            end
            if (br_start) begin
               cnt_load = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               state_d = RESOLVE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESOLVE: begin
            if (con_in) begin
               pc_d = pc_q + $unsigned(off_q);
            end
            done_d  = 1'b1;
            taken_d = con_in;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A bus load overrides everything, including a branch in flight.
      if (pc_in_en) begin
         pc_d     = bus_in;
         state_d  = IDLE;
         cnt_load = 1'b0;
         cnt_dec  = 1'b0;
         done_d   = 1'b0;
         taken_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         br_done  <= 1'b0;
         br_taken <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         br_done  <= done_d;
         br_taken <= taken_d;
      end
   end

   // Offset is pure data; it is only consumed after being loaded.
   always_ff @(posedge clk) begin
      if (cnt_load) begin
         off_q <= off_ext;
      end
   end

   assign pc_out = pc_q;
   assign busy   = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         taken_cnt     <= '0;
         not_taken_cnt <= '0;
      end else if (done_d) begin
         if (taken_d) begin
            taken_cnt <= sat_inc(taken_cnt);
         end else begin
            not_taken_cnt <= sat_inc(not_taken_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: one instance with CON_WAIT=1 and one
// with CON_WAIT=3; branch results are queued at br_start and popped on br_done.
module tb_branch_pc_unit;

   logic        clk;
   logic        clr_n;
   logic        pc_inc, pc_in_en, br_start, con_in;
   logic [31:0] bus_in, ir_in;
   logic [31:0] d1_pc;
   logic        d1_busy, d1_done, d1_taken;

   logic        pc_in_en3, br_start3, con_in3;
   logic [31:0] bus_in3;
   logic [31:0] d3_pc;
   logic        d3_busy, d3_done, d3_taken;

`ifdef BRANCH_STATS_EN
   logic [15:0] d1_tc, d1_ntc, d3_tc, d3_ntc;
`endif

   typedef struct {
      logic        taken;
      logic [31:0] pc;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;

   int n_checks = 0;
   int n_fail   = 0;

   branch_pc_unit #(.CON_WAIT(1)) dut1 (
      .clk      (clk),
      .clr_n    (clr_n),
      .pc_inc   (pc_inc),
      .pc_in_en (pc_in_en),
      .bus_in   (bus_in),
      .br_start (br_start),
      .ir_in    (ir_in),
      .con_in   (con_in),
      .pc_out   (d1_pc),
      .busy     (d1_busy),
      .br_done  (d1_done),
      .br_taken (d1_taken)
`ifdef BRANCH_STATS_EN
      ,
      .taken_cnt     (d1_tc),
      .not_taken_cnt (d1_ntc)
`endif
   );

   branch_pc_unit #(.CON_WAIT(3)) dut3 (
      .clk      (clk),
      .clr_n    (clr_n),
      .pc_inc   (1'b0),
      .pc_in_en (pc_in_en3),
      .bus_in   (bus_in3),
      .br_start (br_start3),
      .ir_in    (ir_in),
      .con_in   (con_in3),
      .pc_out   (d3_pc),
      .busy     (d3_busy),
      .br_done  (d3_done),
      .br_taken (d3_taken)
`ifdef BRANCH_STATS_EN
      ,
      .taken_cnt     (d3_tc),
      .not_taken_cnt (d3_ntc)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sext19(input logic [18:0] o);
      return {{13{o[18]}}, o};
   endfunction

   // Completion monitors
   always @(negedge clk) begin
      if (d1_done) begin
         if (q1.size() == 0) begin
            check_eq("d1_spurious_done", 32'd1, 32'd0);
         end else begin
            e1 = q1.pop_front();
            check_eq("d1_taken", {31'd0, d1_taken}, {31'd0, e1.taken});
            check_eq("d1_pc_at_done", d1_pc, e1.pc);
         end
      end
      if (d3_done) begin
         if (q3.size() == 0) begin
            check_eq("d3_spurious_done", 32'd1, 32'd0);
         end else begin
            e3 = q3.pop_front();
            check_eq("d3_taken", {31'd0, d3_taken}, {31'd0, e3.taken});
            check_eq("d3_pc_at_done", d3_pc, e3.pc);
         end
      end
   end

   task automatic load1(input logic [31:0] v);
      pc_in_en = 1'b1;
      bus_in   = v;
      tick();
      pc_in_en = 1'b0;
      check_eq("d1_load", d1_pc, v);
   endtask

   task automatic load3(input logic [31:0] v);
      pc_in_en3 = 1'b1;
      bus_in3   = v;
      tick();
      pc_in_en3 = 1'b0;
      check_eq("d3_load", d3_pc, v);
   endtask

   task automatic br1(input logic [31:0] pc0, input logic [18:0] off, input logic c,
                      input logic inc_start, input logic noise);
      exp_t        x;
      logic [31:0] pc_s;
      pc_s     = inc_start ? pc0 + 32'd1 : pc0;
      x.taken  = c;
      x.pc     = c ? pc_s + sext19(off) : pc_s;
      ir_in    = {13'h1A5A, off};
      br_start = 1'b1;
      pc_inc   = inc_start;
      con_in   = c;
      q1.push_back(x);
      tick();
      br_start = 1'b0;
      pc_inc   = 1'b0;
      check_eq("d1_busy_wait", {31'd0, d1_busy}, 32'd1);
      check_eq("d1_pc_wait", d1_pc, pc_s);
      if (noise) begin
         br_start = 1'b1;
         pc_inc   = 1'b1;
         ir_in    = 32'h0000_0123;
      end
      tick();
      check_eq("d1_busy_resolve", {31'd0, d1_busy}, 32'd1);
      check_eq("d1_done_early", {31'd0, d1_done}, 32'd0);
      check_eq("d1_pc_resolve", d1_pc, pc_s);
      tick();
      br_start = 1'b0;
      pc_inc   = 1'b0;
      con_in   = 1'b0;
      check_eq("d1_busy_after", {31'd0, d1_busy}, 32'd0);
      check_eq("d1_pc_after", d1_pc, x.pc);
   endtask

   task automatic br3(input logic [31:0] pc0, input logic [18:0] off,
                      input logic glitch, input logic c_res);
      exp_t x;
      x.taken   = c_res;
      x.pc      = c_res ? pc0 + sext19(off) : pc0;
      ir_in     = {13'h0, off};
      br_start3 = 1'b1;
      con_in3   = glitch;
      q3.push_back(x);
      tick();
      br_start3 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq("d3_busy", {31'd0, d3_busy}, 32'd1);
         check_eq("d3_done_early", {31'd0, d3_done}, 32'd0);
         check_eq("d3_pc_hold", d3_pc, pc0);
         if (k == 3) con_in3 = c_res;
         tick();
      end
      con_in3 = 1'b0;
      check_eq("d3_busy_after", {31'd0, d3_busy}, 32'd0);
      check_eq("d3_pc_after", d3_pc, x.pc);
   endtask

   initial begin
      clr_n     = 1'b0;
      pc_inc    = 1'b0;
      pc_in_en  = 1'b0;
      br_start  = 1'b0;
      con_in    = 1'b0;
      bus_in    = '0;
      ir_in     = '0;
      pc_in_en3 = 1'b0;
      br_start3 = 1'b0;
      con_in3   = 1'b0;
      bus_in3   = '0;

      #12;
      check_eq("rst_pc", d1_pc, 32'h0);
      check_eq("rst_busy", {31'd0, d1_busy}, 32'd0);
      check_eq("rst_done", {31'd0, d1_done}, 32'd0);
      check_eq("rst_taken", {31'd0, d1_taken}, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;
      tick();

      // Taken, not-taken, negative offset
      load1(32'h10);
      br1(32'h10, 19'h00005, 1'b1, 1'b0, 1'b0);
      load1(32'h10);
      br1(32'h10, 19'h7FFFE, 1'b0, 1'b0, 1'b0);
      br1(32'h10, 19'h7FFFE, 1'b1, 1'b0, 1'b0);

      // Wrap-around in both directions
      load1(32'hFFFF_FFFF);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check_eq("inc_wrap", d1_pc, 32'h0);
      load1(32'h1);
      br1(32'h1, 19'h7FFFE, 1'b1, 1'b0, 1'b0);

      // Abort during WAIT
      load1(32'h40);
      ir_in    = 32'h5;
      br_start = 1'b1;
      con_in   = 1'b1;
      tick();
      br_start = 1'b0;
      check_eq("abort_busy_before", {31'd0, d1_busy}, 32'd1);
      pc_in_en = 1'b1;
      bus_in   = 32'h200;
      tick();
      pc_in_en = 1'b0;
      check_eq("abort_pc", d1_pc, 32'h200);
      check_eq("abort_idle", {31'd0, d1_busy}, 32'd0);
      tick();
      check_eq("abort_no_done1", {31'd0, d1_done}, 32'd0);
      tick();
      con_in = 1'b0;
      check_eq("abort_no_done2", {31'd0, d1_done}, 32'd0);

      // pc_inc and br_start ignored while busy
      load1(32'h80);
      br1(32'h80, 19'h00003, 1'b0, 1'b0, 1'b1);

      // br_start with pc_inc in the same IDLE cycle
      br1(32'h80, 19'h00010, 1'b1, 1'b1, 1'b0);

      // br_start with pc_in_en: load wins
      ir_in    = 32'h1;
      br_start = 1'b1;
      pc_in_en = 1'b1;
      bus_in   = 32'h300;
      con_in   = 1'b1;
      tick();
      br_start = 1'b0;
      pc_in_en = 1'b0;
      check_eq("ld_vs_br_pc", d1_pc, 32'h300);
      check_eq("ld_vs_br_busy", {31'd0, d1_busy}, 32'd0);
      tick();
      tick();
      con_in = 1'b0;
      check_eq("ld_vs_br_pc_hold", d1_pc, 32'h300);

      // CON_WAIT=3: WAIT-phase glitch ignored, RESOLVE value used
      load3(32'h100);
      br3(32'h100, 19'h00020, 1'b1, 1'b0);
      br3(32'h100, 19'h00020, 1'b0, 1'b1);
      tick();

`ifdef BRANCH_STATS_EN
      check_eq("d1_taken_cnt", {16'd0, d1_tc}, 32'd4);
      check_eq("d1_not_taken_cnt", {16'd0, d1_ntc}, 32'd2);
      check_eq("d3_taken_cnt", {16'd0, d3_tc}, 32'd1);
      check_eq("d3_not_taken_cnt", {16'd0, d3_ntc}, 32'd1);
`endif

      // Reset mid-branch, between clock edges
      load1(32'h55);
      ir_in    = 32'h7;
      br_start = 1'b1;
      con_in   = 1'b1;
      tick();
      br_start = 1'b0;
      #3;
      clr_n = 1'b0;
      #1;
      check_eq("mid_rst_pc", d1_pc, 32'h0);
      check_eq("mid_rst_busy", {31'd0, d1_busy}, 32'd0);
      check_eq("mid_rst_done", {31'd0, d1_done}, 32'd0);
      check_eq("mid_rst_pc3", d3_pc, 32'h0);
`ifdef BRANCH_STATS_EN
      check_eq("mid_rst_tc", {16'd0, d1_tc}, 32'd0);
      check_eq("mid_rst_ntc", {16'd0, d1_ntc}, 32'd0);
`endif
      tick();
      tick();
      con_in = 1'b0;
      check_eq("held_rst_done", {31'd0, d1_done}, 32'd0);

      check_eq("q1_drained", q1.size(), 32'd0);
      check_eq("q3_drained", q3.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
